p405s_icu_ram_dataarray_param: RTL
==================================

Name: p405s_icu_ram_dataArray_param

Overview:
Parametrised single-port I-cache data-array bank that supersedes the fixed 512x128 bank wrappers. Generic width and depth with byte-granular writes and an optional output register. Adds per-byte parity with error injection, a post-reset clearing sweep, and a registered BIST takeover. Sits between the ICU fill/fetch datapath and the SRAM macro; exports the existing BIST and write-capture interface.

Parameters:
DATA_W, 128, data word width in bits; multiple of 8; NB = DATA_W/8 bytes.
ADDR_W, 9, index width; DEPTH = 2**ADDR_W.
OUT_REG, 0, 1 = extra output register stage (read latency 2).
PARITY, 1, 1 = store/check one even-parity bit per byte; 0 = parityErr tied 0.
INIT_CLEAR, 1, 1 = zero the array after reset.

Ports:
CB  in  1  clock (rising edge)
resetCore  in  1  synchronous reset, active-high
cycleDataRam  in  1  functional access request this cycle
readWr  in  1  1 = read, 0 = write
dataIndex  in  [0:ADDR_W-1]  functional word index
byteWrite  in  [0:NB-1]  byte enables; bit 0 = dataIn[0:7]
dataIn  in  [0:DATA_W-1]  write data
errInject  in  1  invert stored parity of written bytes
dataOut  out  [0:DATA_W-1]  read data
dataValid  out  1  one-cycle pulse, dataOut/parityErr valid
parityErr  out  [0:NB-1]  per-byte parity mismatch
initBusy  out  1  clearing sweep in progress
bist_mode  in  1  request BIST ownership
bist_ce_n, bist_we_n  in  1 each  BIST chip enable / write enable, active-low
bist_addr  in  [ADDR_W-1:0]
bist_wr_data  in  [DATA_W-1:0]  bist bit DATA_W-1-i = functional bit i
bist_rd_data  out  [DATA_W-1:0]
cap_mem_addr  out  [ADDR_W-1:0]
cap_mem_wr_data  out  [DATA_W-1:0]  same bit mapping as bist
cap_mem_we  out  1

Behaviour:
- Reset: all outputs 0. FSM enters INIT (INIT_CLEAR=1) or RUN; sweep counter reset to 0. Reset during INIT restarts the sweep at address 0.
- FSM states: INIT, RUN, BIST.
- INIT: each cycle, write word=0, parity=0 at counter; counter +1. After address DEPTH-1 is written, go to RUN; initBusy is high from the cycle after reset through the last sweep cycle (DEPTH cycles). Functional and BIST requests are ignored: no dataValid, no capture.
- RUN->BIST when bist_mode=1 is sampled; BIST->RUN when bist_mode=0 is sampled. Ownership follows the registered state, so the first cycle of a bist_mode change still belongs to the previous owner. Reads in flight complete normally.
- Functional read (RUN, cycleDataRam=1, readWr=1): array read at the clock edge. dataOut and dataValid appear 1 cycle later (2 with OUT_REG=1). dataValid is a single-cycle pulse per read. dataOut and parityErr hold between reads.
- Functional write (RUN, cycleDataRam=1, readWr=0):
  - Writes only the bytes whose byteWrite bit is set; byteWrite=0 is a no-op.
  - Stored parity = XOR of the byte, inverted if errInject=1.
  - A read issued the cycle after a write to the same index returns the new data.
- Parity check: parityErr[b] = stored parity XOR recomputed parity, presented with dataValid.
- Capture: a write with at least one byte enabled produces cap_mem_we=1 for exactly one cycle, the cycle after the write. cap_mem_addr = index; cap_mem_wr_data = dataIn with disabled bytes zeroed. INIT and BIST writes are not captured.
- BIST access (BIST state, bist_ce_n=0):
  - bist_we_n=0 writes the full word with correct parity.
  - bist_we_n=1 reads; bist_rd_data has the same latency as functional reads and holds otherwise.
  - No dataValid during BIST.
- Functional requests in BIST or INIT are dropped silently.

Test Plan:
- Reset, DEPTH=512 -> initBusy high 512 cycles; then read idx 0x1FF -> dataOut=0, dataValid 1 cycle later, parityErr=0.
- Write idx 5, byteWrite=0xFFFF, dataIn=0x0123..EF repeated; read idx 5 next cycle -> same data at +1 cycle (+2 with OUT_REG=1). Cap pulse: addr 5, data bit-reversed.
- Partial write idx 5, byteWrite=0x8001, dataIn all-ones -> bytes 0 and 15 = 0xFF, others unchanged. cap_mem_wr_data has only those bytes set.
- Write idx 7, errInject=1, byteWrite=0x0004, then read -> parityErr=0x0004, data correct.
- bist_mode rises during a functional read -> read completes. Functional write in the next cycle is dropped. BIST write/read at 0x0A0 returns data with 1-cycle latency.
- resetCore pulsed at sweep count 300 -> sweep restarts and initBusy stays high a further 512 cycles. byteWrite=0 write -> no cap_mem_we.

Source files
------------

// File: rtl/p405s_icu_ram_dataarray_param_if.sv
// Functional ICU fetch/fill port of the parametrised I-cache data-array bank.
// Vectors keep the legacy big-endian numbering: byte 0 is dataIn[0:7].
interface p405s_icu_ram_dataarray_param_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 9
);
  localparam int NB = DATA_W / 8;

  logic              cycleDataRam;
  logic              readWr;
  logic [0:ADDR_W-1] dataIndex;
  logic [0:NB-1]     byteWrite;
  logic [0:DATA_W-1] dataIn;
  logic              errInject;
  logic [0:DATA_W-1] dataOut;
  logic              dataValid;
  logic [0:NB-1]     parityErr;

  modport master (
    output cycleDataRam, readWr, dataIndex, byteWrite, dataIn, errInject,
    input  dataOut, dataValid, parityErr
  );

  modport slave (
    input  cycleDataRam, readWr, dataIndex, byteWrite, dataIn, errInject,
    output dataOut, dataValid, parityErr
  );
endinterface

// File: rtl/p405s_icu_ram_dataarray_param.sv
// Parametrised single-port I-cache data-array bank with byte writes, per-byte
// parity, post-reset clearing sweep, registered BIST takeover and write capture.
module p405s_icu_ram_dataarray_param #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 9,
  parameter int OUT_REG    = 0,
  parameter int PARITY     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                 CB,
  input  logic                 resetCore,
  p405s_icu_ram_dataarray_param_if.slave icu,
  output logic                 initBusy,
  input  logic                 bist_mode,
  input  logic                 bist_ce_n,
  input  logic                 bist_we_n,
  input  logic [ADDR_W-1:0]    bist_addr,
  input  logic [DATA_W-1:0]    bist_wr_data,
  output logic [DATA_W-1:0]    bist_rd_data,
  output logic [ADDR_W-1:0]    cap_mem_addr,
  output logic [DATA_W-1:0]    cap_mem_wr_data,
  output logic                 cap_mem_we
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_BIST = 2'd2;

  // Internally everything is descending; a plain copy of a [0:N-1] port puts
  // functional bit 0 at bit N-1, which is exactly the BIST/capture bit mapping.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [NB-1:0]     par_mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] sweep_cnt;

  logic              fn_rd, fn_wr, bist_rd, bist_wr, sweep_wr;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, fn_data, cap_data;
  logic [NB-1:0]     wr_be, wr_par, fn_be;

  logic [DATA_W-1:0] s_word;
  logic [NB-1:0]     s_par;
  logic              s_fv, s_bv;

  logic [DATA_W-1:0] do_q;
  logic [NB-1:0]     dp_q;
  logic              dv_q;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    p = '0;
    for (int unsigned b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction

  assign fn_data  = icu.dataIn;
  assign fn_be    = icu.byteWrite;
  assign fn_rd    = !resetCore && state == ST_RUN  && icu.cycleDataRam &&  icu.readWr;
  assign fn_wr    = !resetCore && state == ST_RUN  && icu.cycleDataRam && !icu.readWr;
  assign bist_rd  = !resetCore && state == ST_BIST && !bist_ce_n &&  bist_we_n;
  assign bist_wr  = !resetCore && state == ST_BIST && !bist_ce_n && !bist_we_n;
  assign sweep_wr = !resetCore && state == ST_INIT;
  assign initBusy = state == ST_INIT;

  always_comb begin
    wr_addr  = icu.dataIndex;
    wr_data  = fn_data;
    wr_par   = byte_par(fn_data) ^ {NB{icu.errInject}};
    wr_be    = '0;
    cap_data = '0;
    for (int unsigned b = 0; b < NB; b++)
      if (fn_be[b]) cap_data[8*b +: 8] = fn_data[8*b +: 8];
    if (sweep_wr) begin
      wr_addr = sweep_cnt;
      wr_data = '0;
      wr_par  = '0;
      wr_be   = '1;
    end else if (bist_wr) begin
      wr_addr = bist_addr;
      wr_data = bist_wr_data;
      wr_par  = byte_par(bist_wr_data);
      wr_be   = '1;
    end else if (fn_wr) begin
      wr_be   = fn_be;
    end
    rd_addr = (state == ST_BIST) ? bist_addr : icu.dataIndex;
  end

  always_ff @(posedge CB) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_be[b]) begin
        mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        par_mem[wr_addr][b]    <= wr_par[b];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge CB) begin
        if (resetCore) begin
          s_fv   <= 1'b0;
          s_bv   <= 1'b0;
          s_word <= '0;
          s_par  <= '0;
        end else begin
          s_fv <= fn_rd;
          s_bv <= bist_rd;
          if (fn_rd || bist_rd) begin
            s_word <= mem[rd_addr];
            s_par  <= par_mem[rd_addr];
          end
        end
      end
    end else begin : g_noreg
      assign s_word = mem[rd_addr];
      assign s_par  = par_mem[rd_addr];
      assign s_fv   = fn_rd;
      assign s_bv   = bist_rd;
    end
  endgenerate

  // Final output registers load only on their own read type so each holds.
  always_ff @(posedge CB) begin
    if (resetCore) begin
      do_q         <= '0;
      dp_q         <= '0;
      dv_q         <= 1'b0;
      bist_rd_data <= '0;
    end else begin
      dv_q <= s_fv;
      if (s_fv) begin
        do_q <= s_word;
        dp_q <= s_par;
      end
      if (s_bv) bist_rd_data <= s_word;
    end
  end

  assign icu.dataOut   = do_q;
  assign icu.dataValid = dv_q;

  generate
    if (PARITY != 0) begin : g_par
      assign icu.parityErr = dp_q ^ byte_par(do_q);
    end else begin : g_nopar
      assign icu.parityErr = '0;
    end
  endgenerate

  always_ff @(posedge CB) begin
    if (resetCore) begin
      state           <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      sweep_cnt       <= '0;
      cap_mem_we      <= 1'b0;
      cap_mem_addr    <= '0;
      cap_mem_wr_data <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == '1) state <= ST_RUN;
        end
        ST_RUN:  if (bist_mode)  state <= ST_BIST;
        ST_BIST: if (!bist_mode) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
      cap_mem_we <= fn_wr && (|fn_be);
      if (fn_wr && (|fn_be)) begin
        cap_mem_addr    <= icu.dataIndex;
        cap_mem_wr_data <= cap_data;
      end
    end
  end
endmodule
